// File: rtl/fetch_pkg.sv
// ----------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction-fetch stage: reset PC default,
// PCSrc redirect encodings, the bubble instruction and the fetch FSM states.
// ----------------------------------------------------------------------------
package fetch_pkg;

    // First fetch address after reset
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

    // Redirect select encodings driven by decode (2'd3 behaves as sequential)
    localparam logic [1:0] PCSRC_SEQ = 2'd0;
    localparam logic [1:0] PCSRC_NPC = 2'd1;
    localparam logic [1:0] PCSRC_JR  = 2'd2;

    // sll $0,$0,0 -- what decode sees during a bubble
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    // Fetch FSM: FETCH issues requests, HOLD parks an acked word during a stall
    typedef enum logic [0:0] {
        ST_FETCH = 1'b0,
        ST_HOLD  = 1'b1
    } fetch_state_e;

    // Sequential successor address, wraps modulo 2^32
    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_redirect_latch.sv
// ----------------------------------------------------------------------------
// fetch_redirect_latch
// One-entry redirect register plus next-PC selection.
//   clk, rst        : clock, asynchronous active-high reset
//   stall           : redirect is ignored while the pipeline is stalled
//   pcsrc           : decode redirect select (NPC / JR / sequential)
//   npc_target      : branch / j / jal target
//   jr_target       : jr / jalr target
//   pc              : current fetch PC
//   advance         : fetch stage is consuming the current PC this cycle
//   next_pc         : value the PC takes when advance is high
// A branch is seen while its delay slot is still being fetched, so the
// target is parked here until the delay slot has been delivered.
// ----------------------------------------------------------------------------
module fetch_redirect_latch
    import fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic [1:0]  pcsrc,
    input  logic [31:0] npc_target,
    input  logic [31:0] jr_target,
    input  logic [31:0] pc,
    input  logic        advance,
    output logic [31:0] next_pc
);

    logic        pending_r;
    logic [31:0] target_r;
    logic        capture_s;
    logic [31:0] cap_target_s;

    // Decode the redirect request presented by decode this cycle
    always_comb begin
        capture_s    = 1'b0;
        cap_target_s = 32'h0000_0000;
        if (!stall) begin
            case (pcsrc)
                PCSRC_NPC: begin
                    capture_s    = 1'b1;
                    cap_target_s = npc_target;
                end
                PCSRC_JR: begin
                    capture_s    = 1'b1;
                    cap_target_s = jr_target;
                end
                default: begin
                    capture_s    = 1'b0;
                    cap_target_s = 32'h0000_0000;
                end
            endcase
        end else begin
            capture_s    = 1'b0;
            cap_target_s = 32'h0000_0000;
        end
    end

    // Next-PC mux: an older pending redirect wins, then a same-cycle capture
    always_comb begin
        if (pending_r) begin
            next_pc = target_r;
        end else if (capture_s) begin
            next_pc = cap_target_s;
        end else begin
            next_pc = pc_plus4(pc);
        end
    end

    // Pending flag and target: set on capture, cleared when the PC advances
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_r <= 1'b0;
            target_r  <= 32'h0000_0000;
        end else if (advance) begin
            pending_r <= 1'b0;
        end else if (capture_s && !pending_r) begin
            pending_r <= 1'b1;
            target_r  <= cap_target_s;
        end
    end

endmodule

// File: rtl/stage_f_fetch.sv
// ----------------------------------------------------------------------------
// stage_f_fetch
// Instruction-fetch stage and IF/ID pipeline register of the five-stage MIPS
// core. Owns the PC, talks to instruction memory over a req/ack port and
// feeds decode. The instruction after a branch/jump (delay slot) is always
// delivered; the redirect takes effect on the PC after it.
//   Clk, Reset        : clock, asynchronous active-high reset
//   Stall             : freezes F and the IF/ID register
//   PCSrc/NPCOut/JRTarget : redirect from decode
//   IMemReq/IMemAddr  : fetch request / word address
//   IMemAck/IMemRData : completion pulse and instruction word
//   InstrD/PC4D/PCD/ValidD : IF/ID register contents
//   AdELF             : fetch address error (FETCH_ADDR_EXC_EN builds only)
// Build option: define FETCH_ADDR_EXC_EN to trap misaligned fetch PCs;
// otherwise the low two address bits are forced to zero.
// ----------------------------------------------------------------------------
module stage_f_fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Stall,
    input  logic [1:0]  PCSrc,
    input  logic [31:0] NPCOut,
    input  logic [31:0] JRTarget,
    output logic        IMemReq,
    output logic [31:0] IMemAddr,
    input  logic        IMemAck,
    input  logic [31:0] IMemRData,
    output logic [31:0] InstrD,
    output logic [31:0] PC4D,
    output logic [31:0] PCD,
`ifdef FETCH_ADDR_EXC_EN
    output logic        AdELF,
`endif
    output logic        ValidD
);

    fetch_state_e state_r;
    fetch_state_e state_nxt_s;
    logic [31:0]  pc_r;
    logic [31:0]  pc4_s;
    logic [31:0]  next_pc_s;
    logic [31:0]  hold_instr_r;
    logic [31:0]  instr_r;
    logic [31:0]  pc4d_r;
    logic [31:0]  pcd_r;
    logic         valid_r;
    logic         misaligned_s;
    logic         advance_s;
    logic         hold_we_s;
    logic         load_s;
    logic [31:0]  ld_instr_s;
    logic [31:0]  ld_pc4_s;
    logic [31:0]  ld_pc_s;
    logic         ld_valid_s;

    assign pc4_s = pc_plus4(pc_r);

    // A misaligned PC never reaches memory when the address trap is built in
`ifdef FETCH_ADDR_EXC_EN
    assign misaligned_s = (pc_r[1:0] != 2'b00);
    assign IMemAddr     = pc_r;
`else
    assign misaligned_s = 1'b0;
    assign IMemAddr     = {pc_r[31:2], 2'b00};
`endif

    // Request only from FETCH; the address stays put until the ack arrives
    assign IMemReq = (state_r == ST_FETCH) && !misaligned_s;

    fetch_redirect_latch u_redirect (
        .clk        (Clk),
        .rst        (Reset),
        .stall      (Stall),
        .pcsrc      (PCSrc),
        .npc_target (NPCOut),
        .jr_target  (JRTarget),
        .pc         (pc_r),
        .advance    (advance_s),
        .next_pc    (next_pc_s)
    );

    // FSM next state and IF/ID load selection
    always_comb begin
        state_nxt_s = state_r;
        load_s      = 1'b0;
        ld_instr_s  = NOP_INSTR;
        ld_pc4_s    = 32'h0000_0000;
        ld_pc_s     = 32'h0000_0000;
        ld_valid_s  = 1'b0;
        advance_s   = 1'b0;
        hold_we_s   = 1'b0;
        case (state_r)
            ST_FETCH: begin
                if (misaligned_s) begin
                    // Deliver an address-error marker in place of an instruction
                    if (!Stall) begin
                        load_s     = 1'b1;
                        ld_pc4_s   = pc4_s;
                        ld_pc_s    = pc_r;
                        ld_valid_s = 1'b1;
                        advance_s  = 1'b1;
                    end else begin
                        load_s = 1'b0;
                    end
                end else if (IMemAck) begin
                    if (!Stall) begin
                        load_s     = 1'b1;
                        ld_instr_s = IMemRData;
                        ld_pc4_s   = pc4_s;
                        ld_pc_s    = pc_r;
                        ld_valid_s = 1'b1;
                        advance_s  = 1'b1;
                    end else begin
                        // Memory will not repeat the word, so park it
                        hold_we_s   = 1'b1;
                        state_nxt_s = ST_HOLD;
                    end
                end else begin
                    // Bubble while waiting; defaults already describe it
                    load_s = !Stall;
                end
            end
            ST_HOLD: begin
                // Any ack seen here is a protocol violation and is ignored
                if (!Stall) begin
                    load_s      = 1'b1;
                    ld_instr_s  = hold_instr_r;
                    ld_pc4_s    = pc4_s;
                    ld_pc_s     = pc_r;
                    ld_valid_s  = 1'b1;
                    advance_s   = 1'b1;
                    state_nxt_s = ST_FETCH;
                end else begin
                    state_nxt_s = ST_HOLD;
                end
            end
            default: begin
                state_nxt_s = ST_FETCH;
            end
        endcase
    end

    // PC, FSM state and hold buffer
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_r      <= ST_FETCH;
            pc_r         <= RESET_PC;
            hold_instr_r <= NOP_INSTR;
        end else begin
            state_r <= state_nxt_s;
            if (advance_s) begin
                pc_r <= next_pc_s;
            end
            if (hold_we_s) begin
                hold_instr_r <= IMemRData;
            end
        end
    end

    // IF/ID pipeline register
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            instr_r <= NOP_INSTR;
            pc4d_r  <= 32'h0000_0000;
            pcd_r   <= 32'h0000_0000;
            valid_r <= 1'b0;
        end else if (load_s) begin
            instr_r <= ld_instr_s;
            pc4d_r  <= ld_pc4_s;
            pcd_r   <= ld_pc_s;
            valid_r <= ld_valid_s;
        end
    end

`ifdef FETCH_ADDR_EXC_EN
    logic adel_r;

    // Address-error flag travels with the IF/ID entry it belongs to
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            adel_r <= 1'b0;
        end else if (load_s) begin
            adel_r <= misaligned_s;
        end
    end

    assign AdELF = adel_r;
`endif

    assign InstrD = instr_r;
    assign PC4D   = pc4d_r;
    assign PCD    = pcd_r;
    assign ValidD = valid_r;

endmodule

// File: tb/tb_stage_f_fetch.sv
// ----------------------------------------------------------------------------
// tb_stage_f_fetch
// Directed bench for stage_f_fetch. Expected IF/ID entries are queued by the
// stimulus sequence; a monitor pops one each time the DUT loads a real
// instruction. A behavioural memory with programmable latency answers
// requests. Extra point checks cover request/address behaviour.
// ----------------------------------------------------------------------------
module tb_stage_f_fetch;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
        logic [31:0] pc;
    } exp_t;

    logic        Clk;
    logic        Reset;
    logic        Stall;
    logic [1:0]  PCSrc;
    logic [31:0] NPCOut;
    logic [31:0] JRTarget;
    logic        IMemReq;
    logic [31:0] IMemAddr;
    logic        IMemAck;
    logic [31:0] IMemRData;
    logic [31:0] InstrD;
    logic [31:0] PC4D;
    logic [31:0] PCD;
    logic        ValidD;
`ifdef FETCH_ADDR_EXC_EN
    logic        AdELF;
`endif

    int   n_cmp = 0;
    int   n_bad = 0;
    int   lat   = 1;
    int   wait_cnt = 0;
    logic stall_q = 1'b0;
    exp_t exp_q[$];

    stage_f_fetch dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Stall     (Stall),
        .PCSrc     (PCSrc),
        .NPCOut    (NPCOut),
        .JRTarget  (JRTarget),
        .IMemReq   (IMemReq),
        .IMemAddr  (IMemAddr),
        .IMemAck   (IMemAck),
        .IMemRData (IMemRData),
        .InstrD    (InstrD),
        .PC4D      (PC4D),
        .PCD       (PCD),
`ifdef FETCH_ADDR_EXC_EN
        .AdELF     (AdELF),
`endif
        .ValidD    (ValidD)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Memory contents: the test word at 0x3000, an address tag elsewhere
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_3000) return 32'h2408_0001;
        return {16'hC0DE, a[15:0]};
    endfunction

    // Memory model: decides at each falling edge whether to ack at the next rise
    initial begin
        IMemAck   = 1'b0;
        IMemRData = 32'h0;
        forever begin
            @(negedge Clk);
            if (Reset || !IMemReq) begin
                IMemAck  = 1'b0;
                wait_cnt = 0;
            end else if (wait_cnt >= lat - 1) begin
                IMemAck   = 1'b1;
                IMemRData = mem_word(IMemAddr);
                wait_cnt  = 0;
            end else begin
                IMemAck  = 1'b0;
                wait_cnt = wait_cnt + 1;
            end
        end
    end

    // Remember whether the last edge was stalled (IF/ID holds on stalled edges)
    always @(posedge Clk) stall_q <= Stall;

    // Scoreboard monitor: every unstalled edge that leaves ValidD=1 is a delivery
    always @(negedge Clk) begin
        if (!Reset && ValidD && !stall_q) begin
            n_cmp = n_cmp + 1;
            if (exp_q.size() == 0) begin
                n_bad = n_bad + 1;
                $display("FAIL sb_unexpected: got instr=%h pc=%h, expected no delivery", InstrD, PCD);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (InstrD !== e.instr || PC4D !== e.pc4 || PCD !== e.pc) begin
                    n_bad = n_bad + 1;
                    $display("FAIL sb_deliver: got instr=%h pc4=%h pc=%h, expected instr=%h pc4=%h pc=%h",
                             InstrD, PC4D, PCD, e.instr, e.pc4, e.pc);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] instr, input logic [31:0] pc4, input logic [31:0] pc);
        exp_t e;
        e.instr = instr;
        e.pc4   = pc4;
        e.pc    = pc;
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(negedge Clk);
        #1;
    endtask

    initial begin
        Reset    = 1'b1;
        Stall    = 1'b0;
        PCSrc    = 2'd0;
        NPCOut   = 32'h0;
        JRTarget = 32'h0;
        repeat (2) @(posedge Clk);
        #1;
        chk("rst_instr", InstrD, 32'h0);
        chk("rst_pc4",   PC4D,   32'h0);
        chk("rst_pcd",   PCD,    32'h0);
        chk("rst_valid", {31'h0, ValidD}, 32'h0);

        // Expected delivery order, hand-derived from the sequence below
        push(32'h2408_0001, 32'h0000_3004, 32'h0000_3000);
        push(32'hC0DE_3004, 32'h0000_3008, 32'h0000_3004);
        push(32'hC0DE_3008, 32'h0000_300C, 32'h0000_3008);
        push(32'hC0DE_300C, 32'h0000_3010, 32'h0000_300C);
        push(32'hC0DE_3010, 32'h0000_3014, 32'h0000_3010);
        push(32'hC0DE_3014, 32'h0000_3018, 32'h0000_3014);
        push(32'hC0DE_3040, 32'h0000_3044, 32'h0000_3040);
        push(32'hC0DE_3044, 32'h0000_3048, 32'h0000_3044);
        push(32'hC0DE_3100, 32'h0000_3104, 32'h0000_3100);
        push(32'hC0DE_3104, 32'h0000_3108, 32'h0000_3104);
`ifdef FETCH_ADDR_EXC_EN
        push(32'h0000_0000, 32'h0000_3106, 32'h0000_3102);
`else
        push(32'hC0DE_3100, 32'h0000_3106, 32'h0000_3102);
`endif

        @(posedge Clk);
        #3 Reset = 1'b0;

        // Zero-wait memory
        step();
        chk("first_req",  {31'h0, IMemReq}, 32'h1);
        chk("first_addr", IMemAddr, 32'h0000_3000);
        step();
        chk("zw_instr", InstrD, 32'h2408_0001);
        chk("zw_pc4",   PC4D,   32'h0000_3004);
        chk("zw_valid", {31'h0, ValidD}, 32'h1);
        chk("zw_addr",  IMemAddr, 32'h0000_3004);
        step();
        Stall = 1'b1;                          // ack at 0x3008 lands while stalled
        step();
        chk("hold_req0",   {31'h0, IMemReq}, 32'h0);
        chk("hold_ifid",   InstrD, 32'hC0DE_3004);
        step();
        chk("hold_req1",   {31'h0, IMemReq}, 32'h0);
        Stall = 1'b0;
        step();
        chk("hold_rel_instr", InstrD, 32'hC0DE_3008);
        chk("hold_rel_pcd",   PCD,    32'h0000_3008);
        lat = 3;

        // Three-cycle memory: two bubbles between instructions
        step();
        step();
        chk("lat3_v0", {31'h0, ValidD}, 32'h0);
        step();
        chk("lat3_v1", {31'h0, ValidD}, 32'h0);
        step();
        chk("lat3_v2", {31'h0, ValidD}, 32'h1);
        chk("lat3_pcd",  PCD,      32'h0000_3010);
        chk("lat3_addr", IMemAddr, 32'h0000_3014);
        PCSrc  = 2'd1;                          // beq at 0x3010 now in decode
        NPCOut = 32'h0000_3040;
        step();
        PCSrc  = 2'd0;
        NPCOut = 32'h0BAD_0000;                 // must not disturb the parked target
        step();
        chk("beq_addr_stable", IMemAddr, 32'h0000_3014);
        step();
        chk("beq_slot_pcd", PCD,      32'h0000_3014);
        chk("beq_target",   IMemAddr, 32'h0000_3040);
        lat = 1;
        step();
        step();
        chk("jr_pre_pcd", PCD, 32'h0000_3040);
        Stall    = 1'b1;                        // jr asserted while stalled: ignored
        PCSrc    = 2'd2;
        JRTarget = 32'h0000_3200;
        step();
        chk("jr_hold_req",  {31'h0, IMemReq}, 32'h0);
        chk("jr_hold_ifid", InstrD, 32'hC0DE_3040);
        Stall    = 1'b0;
        JRTarget = 32'h0000_3100;
        step();
        chk("jr_slot_pcd", PCD,      32'h0000_3044);
        chk("jr_target",   IMemAddr, 32'h0000_3100);
        PCSrc = 2'd0;
        step();
        chk("jr_tgt_pcd", PCD, 32'h0000_3100);
        PCSrc    = 2'd2;                        // jump to a misaligned address
        JRTarget = 32'h0000_3102;
        step();
        PCSrc = 2'd0;
`ifdef FETCH_ADDR_EXC_EN
        chk("adel_noreq", {31'h0, IMemReq}, 32'h0);
`else
        chk("mis_addr_forced", IMemAddr, 32'h0000_3100);
`endif
        step();
        chk("mis_pcd",   PCD, 32'h0000_3102);
        chk("mis_valid", {31'h0, ValidD}, 32'h1);
`ifdef FETCH_ADDR_EXC_EN
        chk("adel_flag",  {31'h0, AdELF}, 32'h1);
        chk("adel_instr", InstrD, 32'h0);
`endif
        Reset = 1'b1;
        step();
        step();
        chk("end_rst_valid", {31'h0, ValidD}, 32'h0);
        chk("sb_drained", exp_q.size(), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
